// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the phase_controller instruction sequencer.
// Helper functions classify an instruction word for the memory, writeback and branch strobes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_P4   = 3'd4,
    ST_P5   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  localparam logic [5:0] OP_HLT    = 6'b101100;
  localparam logic [5:0] OP_CMP    = 6'b110101;
  localparam logic [4:0] BR_PREFIX = 5'b10111;

  localparam int PH_P1 = 0;
  localparam int PH_P2 = 1;
  localparam int PH_P3 = 2;
  localparam int PH_P4 = 3;
  localparam int PH_P5 = 4;

  // Loads (00) and stores (01) touch data memory in P4.
  function automatic logic is_mem_op(input logic [15:0] word);
    return (word[15:14] == 2'b00) || (word[15:14] == 2'b01);
  endfunction

  // Loads and class-11 ALU ops write back, except CMP which only sets flags.
  function automatic logic is_wb_op(input logic [15:0] word);
    return (word[15:14] == 2'b00) ||
           ((word[15:14] == 2'b11) && (word[15:10] != OP_CMP));
  endfunction

  function automatic logic is_branch_op(input logic [15:0] word);
    return word[15:11] == BR_PREFIX;
  endfunction

endpackage

// File: rtl/phase_controller.sv
// Five-phase instruction sequencer and PC owner; strobes and phase are registered from next state.
// Optional single-step mode is enabled by defining PHASE_STEP_EN.
module phase_controller
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [15:0]     instr,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            step,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic [5:0]      instruction_six,
  output logic            alu_control_unit_e,
  output logic            reg_rd_e,
  output logic            mem_e,
  output logic            wb_e,
  output logic [4:0]      phase,
  output logic            halted
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     ir_reg, ir_next;
  logic [4:0]      phase_reg, phase_next;
  logic            alu_e_reg, alu_e_next;
  logic            reg_rd_reg, reg_rd_next;
  logic            mem_e_reg, mem_e_next;
  logic            wb_e_reg, wb_e_next;
  logic            halted_reg, halted_next;

  logic            start_ok;
  logic            continue_ok;

`ifdef PHASE_STEP_EN
  logic step_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_reg <= 1'b0;
    end else begin
      step_prev_reg <= step;
    end
  end

  // One instruction per rising edge of step; every instruction returns to IDLE.
  assign start_ok    = run && step && !step_prev_reg;
  assign continue_ok = 1'b0;
`else
  logic unused_step;
  assign unused_step = step;
  assign start_ok    = run;
  assign continue_ok = run;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) state_next = ST_P1;
      end
      ST_P1: begin
        ir_next    = instr;
        pc_next    = pc_reg + 1'b1;
        state_next = ST_P2;
      end
      ST_P2: begin
        state_next = (ir_reg[15:10] == OP_HLT) ? ST_HALT : ST_P3;
      end
      ST_P3: state_next = ST_P4;
      ST_P4: state_next = ST_P5;
      ST_P5: begin
        if (is_branch_op(ir_reg) && br_taken) pc_next = br_target;
        state_next = continue_ok ? ST_P1 : ST_IDLE;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Decode outputs for the state being entered so they line up with it once registered.
  always_comb begin
    phase_next  = '0;
    reg_rd_next = 1'b0;
    alu_e_next  = 1'b0;
    mem_e_next  = 1'b0;
    wb_e_next   = 1'b0;
    halted_next = 1'b0;
    case (state_next)
      ST_P1: phase_next[PH_P1] = 1'b1;
      ST_P2: begin
        phase_next[PH_P2] = 1'b1;
        reg_rd_next       = 1'b1;
      end
      ST_P3: begin
        phase_next[PH_P3] = 1'b1;
        alu_e_next        = 1'b1;
      end
      ST_P4: begin
        phase_next[PH_P4] = 1'b1;
        mem_e_next        = is_mem_op(ir_next);
      end
      ST_P5: begin
        phase_next[PH_P5] = 1'b1;
        wb_e_next         = is_wb_op(ir_next);
      end
      ST_HALT: halted_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= RESET_PC;
      ir_reg     <= '0;
      phase_reg  <= '0;
      reg_rd_reg <= 1'b0;
      alu_e_reg  <= 1'b0;
      mem_e_reg  <= 1'b0;
      wb_e_reg   <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      ir_reg     <= ir_next;
      phase_reg  <= phase_next;
      reg_rd_reg <= reg_rd_next;
      alu_e_reg  <= alu_e_next;
      mem_e_reg  <= mem_e_next;
      wb_e_reg   <= wb_e_next;
      halted_reg <= halted_next;
    end
  end

  assign pc                 = pc_reg;
  assign ir                 = ir_reg;
  assign instruction_six    = ir_reg[15:10];
  assign phase              = phase_reg;
  assign reg_rd_e           = reg_rd_reg;
  assign alu_control_unit_e = alu_e_reg;
  assign mem_e              = mem_e_reg;
  assign wb_e               = wb_e_reg;
  assign halted             = halted_reg;

endmodule

// File: tb/tb_phase_controller.sv
// Self-checking bench for phase_controller: instruction table with a per-cycle strobe scoreboard,
// plus hand sequences for run drop, mid-instruction reset, HALT and (with PHASE_STEP_EN) stepping.
module tb_phase_controller;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] instr;
  logic        br_taken;
  logic [15:0] br_target;
  logic        step;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [5:0]  instruction_six;
  logic        alu_control_unit_e;
  logic        reg_rd_e;
  logic        mem_e;
  logic        wb_e;
  logic [4:0]  phase;
  logic        halted;

  int errors = 0;
  int checks = 0;

  phase_controller #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
    .br_taken(br_taken), .br_target(br_target), .step(step),
    .pc(pc), .ir(ir), .instruction_six(instruction_six),
    .alu_control_unit_e(alu_control_unit_e), .reg_rd_e(reg_rd_e),
    .mem_e(mem_e), .wb_e(wb_e), .phase(phase), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        br_taken;
    logic [15:0] br_target;
    logic        mem;
    logic        wb;
    logic [15:0] pc_next;
  } vec_t;

  typedef struct {
    logic [4:0] phase;
    logic       rd;
    logic       alu;
    logic       mem;
    logic       wb;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_instr(input logic mem, input logic wb);
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.phase = 5'b00001 << k;
      e.rd    = (k == 1);
      e.alu   = (k == 2);
      e.mem   = (k == 3) && mem;
      e.wb    = (k == 4) && wb;
      sb.push_back(e);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("phase", {27'd0, phase}, {27'd0, e.phase});
    check("reg_rd_e", {31'd0, reg_rd_e}, {31'd0, e.rd});
    check("alu_e", {31'd0, alu_control_unit_e}, {31'd0, e.alu});
    check("mem_e", {31'd0, mem_e}, {31'd0, e.mem});
    check("wb_e", {31'd0, wb_e}, {31'd0, e.wb});
    check("halted", {31'd0, halted}, 32'd0);
  endtask

  // Leaves the bench at a negedge where phase==P1; a timeout counts as a failure.
  task automatic wait_p1();
    int n;
`ifdef PHASE_STEP_EN
    if (phase != 5'b00001) step = 1'b1;
`endif
    n = 0;
    while (phase != 5'b00001 && n < 10) begin
      @(negedge clk);
      n++;
    end
    step = 1'b0;
    if (phase != 5'b00001) check("wait_p1_timeout", {27'd0, phase}, 32'd1);
  endtask

  task automatic run_one(input logic [15:0] ins, input logic mem, input logic wb);
    instr = ins;
    push_instr(mem, wb);
    pop_compare();
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      pop_compare();
      if (k == 1) begin
        check("ir", {16'd0, ir}, {16'd0, ins});
        check("instruction_six", {26'd0, instruction_six}, {26'd0, ins[15:10]});
      end
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{16'hC000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001};
    vecs[1]  = '{16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002};
    vecs[2]  = '{16'h4000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003};
    vecs[3]  = '{16'hD400, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004};
    vecs[4]  = '{16'hBC00, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0040};
    vecs[5]  = '{16'hBC00, 1'b0, 16'h0080, 1'b0, 1'b0, 16'h0041};
    vecs[6]  = '{16'hB800, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234};
    vecs[7]  = '{16'h8000, 1'b1, 16'h0099, 1'b0, 1'b0, 16'h1235};
    vecs[8]  = '{16'hFC00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1236};
    vecs[9]  = '{16'hBC00, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
    vecs[10] = '{16'hC000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};

    rst_n = 1'b0; run = 1'b0; instr = 16'h0; br_taken = 1'b0; br_target = 16'h0; step = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", {16'd0, pc}, 32'h0);
    check("rst_ir", {16'd0, ir}, 32'h0);
    check("rst_phase", {27'd0, phase}, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'h0);
    check("rst_strobes", {28'd0, alu_control_unit_e, reg_rd_e, mem_e, wb_e}, 32'h0);

    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    begin
      logic [15:0] start_pc;
      start_pc = 16'h0000;
      for (int i = 0; i < 11; i++) begin
        wait_p1();
        check("pc_start", {16'd0, pc}, {16'd0, start_pc});
        br_taken  = vecs[i].br_taken;
        br_target = vecs[i].br_target;
        run_one(vecs[i].instr, vecs[i].mem, vecs[i].wb);
        @(negedge clk);
        check("pc_next", {16'd0, pc}, {16'd0, vecs[i].pc_next});
        $display("instr=%h br=%b tgt=%h pc_next=%h", vecs[i].instr, vecs[i].br_taken,
                 vecs[i].br_target, pc);
        start_pc = vecs[i].pc_next;
      end
    end
    br_taken = 1'b0;

    // run dropped during P2: instruction still completes, then IDLE
    wait_p1();
    check("runA_pc", {16'd0, pc}, 32'h0000);
    instr = 16'hC000;
    push_instr(1'b0, 1'b1);
    pop_compare();
    @(negedge clk);
    pop_compare();
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pop_compare();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_phase", {27'd0, phase}, 32'h0);
    end
    check("idle_pc", {16'd0, pc}, 32'h0001);
    $display("run drop: pc=%h phase=%b", pc, phase);

    // async reset in P3 discards the instruction
    run = 1'b1;
    wait_p1();
    check("runB_pc", {16'd0, pc}, 32'h0001);
    instr = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("p3_alu", {31'd0, alu_control_unit_e}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_pc", {16'd0, pc}, 32'h0);
    check("async_ir", {16'd0, ir}, 32'h0);
    check("async_phase", {27'd0, phase}, 32'h0);
    check("async_alu", {31'd0, alu_control_unit_e}, 32'h0);
    $display("reset in P3: pc=%h ir=%h phase=%b", pc, ir, phase);
    @(negedge clk);
    rst_n = 1'b1;

    // HLT: sticky halt, no ALU strobe, run ignored, reset clears
    instr = 16'hB000;
    wait_p1();
    check("hlt_pc", {16'd0, pc}, 32'h0);
    @(negedge clk);
    check("hlt_rd", {31'd0, reg_rd_e}, 32'h1);
    check("hlt_six", {26'd0, instruction_six}, 32'h2C);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("hlt_halted", {31'd0, halted}, 32'h1);
      check("hlt_phase", {27'd0, phase}, 32'h0);
      check("hlt_alu", {31'd0, alu_control_unit_e}, 32'h0);
      run = ~run;
    end
    rst_n = 1'b0;
    #1;
    check("hlt_clear", {31'd0, halted}, 32'h0);
    $display("halt: cleared by reset, halted=%b", halted);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;

`ifdef PHASE_STEP_EN
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("step_wait", {27'd0, phase}, 32'h0);
    end
    step = 1'b1;
    @(negedge clk);
    instr = 16'hC000;
    push_instr(1'b0, 1'b1);
    pop_compare();
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      pop_compare();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("step_idle", {27'd0, phase}, 32'h0);
    end
    step = 1'b0;
    $display("step: one instruction, pc=%h", pc);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
